// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared ratios and count-width helper
// for the S/PDIF clock divider slice.
package clkdiv_pkg;

  localparam int DIV_A_DEF = 5;
  localparam int DIV_B_DEF = 25;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkdiv125_if.sv
// clkdiv125_if: bundle of divided clocks and tick
// strobes, driven by the divider, read by consumers.
interface clkdiv125_if;

  logic clk_out5;
  logic clk_out125;
  logic tick5;
  logic tick125;

  modport master (
    output clk_out5,
    output clk_out125,
    output tick5,
    output tick125
  );

  modport slave (
    input clk_out5,
    input clk_out125,
    input tick5,
    input tick125
  );

endinterface

// File: rtl/clkdiv_stage.sv
// clkdiv_stage: clock-enabled modulo-N counter with
// registered half-duty clock and wrap tick.
module clkdiv_stage
  import clkdiv_pkg::*;
#(
  parameter int N = DIV_A_DEF
) (
  input  logic clk_in,
  input  logic reset,
  input  logic en,
  output logic wrap,
  output logic clk_out,
  output logic tick
);

  localparam int W = cnt_w(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] HALF = W'(N / 2);

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;

  always_comb begin
    wrap      = en && (cnt_q == LAST);
    cnt_d     = cnt_q;
    if (en)
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    // decode uses the pre-edge count
    clk_out_d = (cnt_q < HALF);
    tick_d    = wrap;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clkdiv125.sv
// clkdiv125: two-stage single-clock divider, stage B
// clock-enabled by stage A wrap (no ripple clocks).
module clkdiv125
  import clkdiv_pkg::*;
#(
  parameter int DIV_A = DIV_A_DEF,
  parameter int DIV_B = DIV_B_DEF
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_out5,
  output logic clk_out125,
  output logic tick5,
  output logic tick125
);

  logic wrap_a;
  logic wrap_b;

  clkdiv_stage #(.N(DIV_A)) u_stage_a (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (1'b1),
    .wrap    (wrap_a),
    .clk_out (clk_out5),
    .tick    (tick5)
  );

  clkdiv_stage #(.N(DIV_B)) u_stage_b (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (wrap_a),
    .wrap    (wrap_b),
    .clk_out (clk_out125),
    .tick    (tick125)
  );

  // stage B can only wrap on a stage A wrap
  a_wrap_nest : assert property (
    @(posedge clk_in) disable iff (reset)
    wrap_b |-> wrap_a
  );

endmodule

// File: tb/tb_clkdiv125.sv
// tb_clkdiv125: directed checks of the default 5/25
// divider and a 2/3 parameter sweep instance.
module tb_clkdiv125;

  logic clk = 1'b0;
  logic reset = 1'b1;

  clkdiv125_if d ();

  logic s_c5, s_c125, s_t5, s_t125;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clkdiv125 u_dut (
    .clk_in     (clk),
    .reset      (reset),
    .clk_out5   (d.clk_out5),
    .clk_out125 (d.clk_out125),
    .tick5      (d.tick5),
    .tick125    (d.tick125)
  );

  clkdiv125 #(.DIV_A(2), .DIV_B(3)) u_sweep (
    .clk_in     (clk),
    .reset      (reset),
    .clk_out5   (s_c5),
    .clk_out125 (s_c125),
    .tick5      (s_t5),
    .tick125    (s_t125)
  );

  // {clk_out5, clk_out125, tick5, tick125}
  function automatic logic [3:0] obs_main();
    return {d.clk_out5, d.clk_out125, d.tick5, d.tick125};
  endfunction

  function automatic logic [3:0] obs_sweep();
    return {s_c5, s_c125, s_t5, s_t125};
  endfunction

  // expected outputs after edge e (e>=1) for ratios a, b
  function automatic logic [3:0] model(
    input int e, input int a, input int b);
    int p;
    p = a * b;
    return {((e - 1) % a) < (a / 2),
            ((e - 1) % p) < ((b / 2) * a),
            (e % a) == 0,
            (e % p) == 0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_main() !== 4'b0000) begin
        errs++;
        $display("FAIL reset_hold[%0d] got=%b want=0000",
                 i, obs_main());
      end
    end
    checks++;
    if (obs_sweep() !== 4'b0000) begin
      errs++;
      $display("FAIL reset_hold_sweep got=%b want=0000",
               obs_sweep());
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs_main() !== 4'b1100) begin
      errs++;
      $display("FAIL reset_e1 got=%b want=1100", obs_main());
    end
    checks++;
    if (obs_sweep() !== 4'b1100) begin
      errs++;
      $display("FAIL reset_e1_sweep got=%b want=1100",
               obs_sweep());
    end
  endtask

  task automatic test_waveform();
    logic p5, p125;
    int rise5, rise125, n_t5, n_t125;
    int r125_e [4];
    rise5 = 0; rise125 = 0; n_t5 = 0; n_t125 = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    p5 = d.clk_out5;
    p125 = d.clk_out125;
    for (int e = 1; e <= 500; e++) begin
      step();
      checks++;
      if (obs_main() !== model(e, 5, 25)) begin
        errs++;
        $display("FAIL wave_e%0d got=%b want=%b",
                 e, obs_main(), model(e, 5, 25));
      end
      if (!p5 && d.clk_out5) rise5++;
      if (!p125 && d.clk_out125) begin
        if (rise125 < 4) r125_e[rise125] = e;
        rise125++;
        checks++;
        if (p5 || !d.clk_out5) begin
          errs++;
          $display("FAIL align_e%0d c5_prev=%b c5=%b want=0,1",
                   e, p5, d.clk_out5);
        end
      end
      if (d.tick5) n_t5++;
      if (d.tick125) begin
        n_t125++;
        checks++;
        if (d.tick5 !== 1'b1) begin
          errs++;
          $display("FAIL t125_implies_t5_e%0d got=%b want=1",
                   e, d.tick5);
        end
      end
      p5 = d.clk_out5;
      p125 = d.clk_out125;
    end
    checks++;
    if (rise5 != 100) begin
      errs++;
      $display("FAIL rise5_count got=%0d want=100", rise5);
    end
    checks++;
    if (n_t5 != 100) begin
      errs++;
      $display("FAIL tick5_count got=%0d want=100", n_t5);
    end
    checks++;
    if (rise125 != 4) begin
      errs++;
      $display("FAIL rise125_count got=%0d want=4", rise125);
    end
    checks++;
    if (n_t125 != 4) begin
      errs++;
      $display("FAIL tick125_count got=%0d want=4", n_t125);
    end
    if (rise125 == 4) begin
      checks++;
      if (r125_e[0] != 1 || r125_e[1] != 126 ||
          r125_e[2] != 251 || r125_e[3] != 376) begin
        errs++;
        $display("FAIL rise125_edges got=%0d,%0d,%0d,%0d want=1,126,251,376",
                 r125_e[0], r125_e[1], r125_e[2], r125_e[3]);
      end
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 72; e++) step();
    reset = 1'b1;
    step();
    checks++;
    if (obs_main() !== 4'b0000) begin
      errs++;
      $display("FAIL mid_reset got=%b want=0000", obs_main());
    end
    reset = 1'b0;
    for (int e = 1; e <= 130; e++) begin
      step();
      checks++;
      if (obs_main() !== model(e, 5, 25)) begin
        errs++;
        $display("FAIL restart_e%0d got=%b want=%b",
                 e, obs_main(), model(e, 5, 25));
      end
    end
  endtask

  task automatic test_sweep();
    int n_t;
    n_t = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step();
      checks++;
      if (obs_sweep() !== model(e, 2, 3)) begin
        errs++;
        $display("FAIL sweep_e%0d got=%b want=%b",
                 e, obs_sweep(), model(e, 2, 3));
      end
      if (s_t125) n_t++;
    end
    checks++;
    if (n_t != 4) begin
      errs++;
      $display("FAIL sweep_tick_count got=%0d want=4", n_t);
    end
  endtask

  initial begin
    test_reset();
    test_waveform();
    test_mid_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/clkdiv125.md
# clkdiv125

Synchronous two-stage clock divider for the S/PDIF front end. From the single input clock it produces a ÷5 clock, a ÷125 clock (a ÷25 stage cascaded after the ÷5 stage), and one-cycle tick strobes for each stage. Both stages run on `clk_in`; the second stage is clock-enabled by the first stage's wrap, so there is no ripple clocking. Downstream logic should use the ticks as clock enables; `clk_out5` and `clk_out125` are for pins and observation.

## Interface
- `DIV_A`, default 5: first-stage divide ratio; must be ≥ 2.
- `DIV_B`, default 25: second-stage divide ratio, counted in first-stage periods; must be ≥ 2.
- `clk_in`  input  1  sole clock; all registers update on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `clk_out5`  output  1  divided clock, period `DIV_A` cycles of `clk_in`.
- `clk_out125`  output  1  divided clock, period `DIV_A*DIV_B` cycles of `clk_in`.
- `tick5`  output  1  one-cycle strobe, once per `clk_out5` period.
- `tick125`  output  1  one-cycle strobe, once per `clk_out125` period.

## Operation
- Stage A counter `cnt_a` counts 0..DIV_A-1 and wraps to 0. Width is clog2(DIV_A).
- Stage B counter `cnt_b` counts 0..DIV_B-1. It advances only on edges where `cnt_a == DIV_A-1`, and wraps to 0.
- All outputs are registered; nothing is decoded combinationally onto an output.
- On every edge:
  - `clk_out5 <= (cnt_a < DIV_A/2)`, using the pre-edge count and floor division.
  - `clk_out125 <= (cnt_b < DIV_B/2)`, using the pre-edge count.
  - `tick5 <= (cnt_a == DIV_A-1)`.
  - `tick125 <= (cnt_a == DIV_A-1) && (cnt_b == DIV_B-1)`.
- Resulting duty cycles:
  - `clk_out5`: high 2 cycles, low 3 cycles.
  - `clk_out125`: high 60 cycles, low 65 cycles.
- Every rising edge of `clk_out125` coincides with a rising edge of `clk_out5`.
- Reset, sampled on an edge with `reset`=1:
  - `cnt_a` and `cnt_b` go to 0.
  - All four outputs go to 0.
  - Reset takes priority over counting.
- Mid-operation reset has the same effect on the next edge, regardless of the counter phase.
- Non-reset values are unreachable: counters never exceed their modulus.

## Timing
- Number edges E1, E2, … starting at the first edge with `reset`=0.
- Output values after each edge (all outputs are 0 before E1):
  - `clk_out5`: 1 after E1–E2, 0 after E3–E5, 1 after E6; period 5.
  - `tick5`: high only in the cycle following E5, E10, … (the cycle immediately before each `clk_out5` rise).
  - `clk_out125`: 1 after E1–E60, 0 after E61–E125, 1 after E126.
  - `tick125`: high only in the cycle following E125, E250, …
- Latency from reset release to the first `clk_out5` and `clk_out125` high is 1 edge.
- No handshake signals.

## Structure
- One sub-module, `clkdiv_stage`, instantiated twice (stage A and stage B). Parameter `N`. Ports:
  - `clk_in`, `reset`, `en`;
  - `wrap` (combinational, `cnt == N-1 && en`);
  - `clk_out` and `tick` (both registered).
- Stage A has `en`=1. Stage B has `en` = stage A `wrap`. Top-level `tick125` = B's `wrap` registered.
- Shared package `clkdiv_pkg` holds:
  - default ratios `DIV_A_DEF` = 5 and `DIV_B_DEF` = 25;
  - a `clog2`-based count-width function used by `clkdiv_stage`.

## Test plan
- Reset behaviour: hold `reset`=1 for 3 cycles, then release → all outputs 0 during reset; `clk_out5` and `clk_out125` are 1 after E1.
- ÷5 waveform: run 500 cycles → `clk_out5` has exactly 100 periods, each 2 high / 3 low; `tick5` fires 100 times, each immediately before a `clk_out5` rise.
- ÷125 waveform: same run → `clk_out125` has exactly 4 periods, each 60 high / 65 low, rising at E1, E126, E251, E376; `tick125` follows E125, E250, E375, E500.
- Phase alignment: at every `clk_out125` rise, `clk_out5` also rises on the same edge; `tick125` implies `tick5`.
- Mid-operation reset: assert `reset` for 1 cycle at E73 (counter phase 3) → all outputs are 0 the next cycle, then the waveform restarts exactly as at E1.
- Parameter sweep: `DIV_A`=2, `DIV_B`=3 → `clk_out5` is 1 high / 1 low; `clk_out125` is 2 high / 4 low with period 6; `tick125` fires every 6 cycles.
